// File: rtl/compose_chk_pkg.sv
// Shared types and helpers for the inverting-chain checker.
package compose_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } chk_state_e;

  // Width of the optional first-error cycle counter
  localparam int unsigned FE_CYC_W = 16;

  // An odd number of inverting stages flips the expected bit
  function automatic logic exp_inv(input int unsigned depth);
    return depth[0];
  endfunction

endpackage

// File: rtl/compose_chk_hist.sv
// DEPTH-wide history of captured d bits; exp is the oldest bit with chain parity applied.
module compose_chk_hist
  import compose_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic d,
  output logic exp
);

  logic [DEPTH-1:0] hist;
  logic [DEPTH-1:0] nxt_c;

  // Next history word: shift in d at the bottom
  if (DEPTH == 1) begin : g_one
    assign nxt_c = d;
  end else begin : g_many
    assign nxt_c = {hist[DEPTH-2:0], d};
  end

  // History shift register, holds when not enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= nxt_c;
    end
  end

  // Oldest captured bit, inverted for odd-length chains
  assign exp = hist[DEPTH-1] ^ exp_inv(DEPTH);

endmodule

// File: rtl/compose_chk.sv
// Receive-side checker for inverting register chains.
// Optional macro COMPOSE_CHK_FIRST_ERR_EN adds first_err_cyc / first_err_vld.
module compose_chk
  import compose_chk_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  input  logic             q_in,
  output logic             checking,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
`ifdef COMPOSE_CHK_FIRST_ERR_EN
  ,
  output logic [FE_CYC_W-1:0] first_err_cyc,
  output logic                first_err_vld
`endif
);

  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  chk_state_e        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              exp_c;
  logic              shift_en_c;
  logic              hit_c;

  // History freezes only in FAIL; otherwise it tracks every enabled edge
  assign shift_en_c = en && (state_q != FAIL);

  compose_chk_hist #(.DEPTH(DEPTH)) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en_c),
    .d        (d),
    .exp      (exp_c)
  );

  // A counted mismatch: live compare in CHECK, suppressed by clr
  assign hit_c = (state_q == CHECK) && en && (q_in != exp_c) && !clr;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    err_d   = err;
    cnt_d   = err_cnt;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          if (DEPTH == 1) begin
            state_d = CHECK;
          end else begin
            state_d = FILL;
            fill_d  = FILL_W'(1);
          end
        end
      end
      FILL: begin
        if (!en) begin
          state_d = IDLE;
          fill_d  = '0;
        end else if (fill_q == FILL_W'(DEPTH - 1)) begin
          state_d = CHECK;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
      CHECK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (hit_c && (STOP_ON_ERR != 0)) begin
          state_d = FAIL;
        end
      end
      FAIL: begin
        if (clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (hit_c) begin
      err_d = 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) begin
        cnt_d = err_cnt + CNT_W'(1);
      end
    end
    if (clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  // State, fill counter and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fill_q   <= '0;
      checking <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      checking <= (state_d == CHECK);
      err      <= err_d;
      err_cnt  <= cnt_d;
    end
  end

`ifdef COMPOSE_CHK_FIRST_ERR_EN
  logic [FE_CYC_W-1:0] cyc_q, cyc_d, fcyc_d;
  logic                fvld_d;

  // CHECK-cycle counter and first-mismatch capture
  always_comb begin
    cyc_d  = cyc_q;
    fcyc_d = first_err_cyc;
    fvld_d = first_err_vld;
    if ((state_d == CHECK) && (state_q != CHECK)) begin
      cyc_d = '0;
    end else if ((state_q == CHECK) && en && (cyc_q != {FE_CYC_W{1'b1}})) begin
      cyc_d = cyc_q + FE_CYC_W'(1);
    end
    if (hit_c && !first_err_vld) begin
      fcyc_d = cyc_q;
      fvld_d = 1'b1;
    end
    if (clr) begin
      fcyc_d = '0;
      fvld_d = 1'b0;
    end
  end

  // First-error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q         <= '0;
      first_err_cyc <= '0;
      first_err_vld <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      first_err_cyc <= fcyc_d;
      first_err_vld <= fvld_d;
    end
  end
`endif

endmodule

// File: tb/tb_compose_chk.sv
// Bench for compose_chk: five instances observing bench-modelled inverting chains.
module tb_compose_chk;

  localparam int unsigned NI = 5;

  typedef struct {
    logic       en;
    logic       clr;
    logic       d;
    logic       inj;
    logic       chk;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  typedef struct {
    logic       chk;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n, en, clr, d;
  logic [NI-1:0] inj;

  logic [1:0] c2;
  logic [2:0] c3;
  logic [3:0] c4s, c4;
  logic       c1;

  logic       chk_a [NI];
  logic       err_a [NI];
  logic [7:0] cnt_a [NI];
  logic [1:0] cnt3;
  logic [15:0] fc_a [NI];
  logic        fv_a [NI];

  vec_t tab[$];
  exp_t sb[$];
  int   total, bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inverting register chains (each stage stores the complement of its input)
  always @(posedge clk) begin
    c2  <= {~c2[0], ~d};
    c3  <= {~c3[1:0], ~d};
    c4s <= {~c4s[2:0], ~d};
    c4  <= {~c4[2:0], ~d};
    c1  <= ~d;
  end

  assign cnt_a[1] = {6'd0, cnt3};

  compose_chk #(.DEPTH(2), .CNT_W(8), .STOP_ON_ERR(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .q_in(c2[1] ^ inj[0]),
    .checking(chk_a[0]), .err(err_a[0]), .err_cnt(cnt_a[0])
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    , .first_err_cyc(fc_a[0]), .first_err_vld(fv_a[0])
`endif
  );

  compose_chk #(.DEPTH(3), .CNT_W(2), .STOP_ON_ERR(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .q_in(c3[2] ^ inj[1]),
    .checking(chk_a[1]), .err(err_a[1]), .err_cnt(cnt3)
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    , .first_err_cyc(fc_a[1]), .first_err_vld(fv_a[1])
`endif
  );

  compose_chk #(.DEPTH(4), .CNT_W(8), .STOP_ON_ERR(1)) u_d4s (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .q_in(c4s[3] ^ inj[2]),
    .checking(chk_a[2]), .err(err_a[2]), .err_cnt(cnt_a[2])
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    , .first_err_cyc(fc_a[2]), .first_err_vld(fv_a[2])
`endif
  );

  compose_chk #(.DEPTH(4), .CNT_W(8), .STOP_ON_ERR(0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .q_in(c4[3] ^ inj[3]),
    .checking(chk_a[3]), .err(err_a[3]), .err_cnt(cnt_a[3])
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    , .first_err_cyc(fc_a[3]), .first_err_vld(fv_a[3])
`endif
  );

  compose_chk #(.DEPTH(1), .CNT_W(8), .STOP_ON_ERR(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .q_in(c1 ^ inj[4]),
    .checking(chk_a[4]), .err(err_a[4]), .err_cnt(cnt_a[4])
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    , .first_err_cyc(fc_a[4]), .first_err_vld(fv_a[4])
`endif
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, expv);
    end
  endtask

  function automatic void add(input logic a_en, input logic a_clr, input logic a_d,
                              input logic a_inj, input logic a_chk, input logic a_err,
                              input int a_cnt);
    vec_t v;
    v.en = a_en; v.clr = a_clr; v.d = a_d; v.inj = a_inj;
    v.chk = a_chk; v.err = a_err; v.cnt = 8'(a_cnt);
    tab.push_back(v);
  endfunction

  task automatic chk_row(input int sel, input string nm);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty got=0 want=1", nm);
    end else begin
      total--;
      e = sb.pop_front();
      check({nm, ".checking"}, 16'(chk_a[sel]), 16'(e.chk));
      check({nm, ".err"},      16'(err_a[sel]), 16'(e.err));
      check({nm, ".err_cnt"},  16'(cnt_a[sel]), 16'(e.cnt));
    end
  endtask

  // Apply the table to all instances, injecting faults and checking only instance sel
  task automatic run_tab(input int sel, input string nm);
    exp_t e;
    for (int i = 0; i < tab.size(); i++) begin
      en = tab[i].en; clr = tab[i].clr; d = tab[i].d;
      inj = '0;
      inj[sel] = tab[i].inj;
      e.chk = tab[i].chk; e.err = tab[i].err; e.cnt = tab[i].cnt;
      sb.push_back(e);
      @(posedge clk); #1;
      chk_row(sel, $sformatf("%s[%0d]", nm, i));
    end
    tab.delete();
    inj = '0; en = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = 1'b0; inj = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = 1'b0; inj = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < int'(NI); i++) begin
      check($sformatf("rst%0d.checking", i), 16'(chk_a[i]), 16'd0);
      check($sformatf("rst%0d.err", i),      16'(err_a[i]), 16'd0);
      check($sformatf("rst%0d.err_cnt", i),  16'(cnt_a[i]), 16'd0);
    end
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    check("rst.first_err_vld", 16'(fv_a[3]), 16'd0);
    check("rst.first_err_cyc", fc_a[3], 16'd0);
`endif
    rst_n = 1'b1;

    // DEPTH=2 clean stream
    add(1,0,1,0, 0,0,0); add(1,0,0,0, 1,0,0); add(1,0,1,0, 1,0,0);
    add(1,0,1,0, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0);
    add(0,0,1,0, 0,0,0);
    run_tab(0, "d2");

    // DEPTH=3, CNT_W=2: single error, sticky, clr, clr beats mismatch, saturation
    do_reset();
    add(1,0,1,0, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,1,0, 1,0,0);
    add(1,0,0,0, 1,0,0); add(1,0,1,1, 1,1,1); add(1,0,1,0, 1,1,1);
    add(1,1,0,0, 1,0,0); add(1,1,1,1, 1,0,0);
    for (int k = 0; k < 6; k++) add(1, 0, logic'(k % 2), 1, 1, 1, (k + 1 > 3) ? 3 : k + 1);
    add(1,1,0,0, 1,0,0);
    run_tab(1, "d3");

    // DEPTH=4 with stop-on-error: FAIL holds, clr returns to IDLE then refills
    do_reset();
    add(1,0,1,0, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,1,0, 1,0,0);
    add(1,0,0,0, 1,0,0); add(1,0,1,1, 0,1,1); add(1,0,0,1, 0,1,1); add(1,0,1,0, 0,1,1);
    add(1,1,1,0, 0,0,0);
    add(1,0,0,0, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,0,0, 1,0,0);
    add(1,0,1,0, 1,0,0); add(1,0,0,0, 1,0,0);
    run_tab(2, "d4s");

    // DEPTH=4: error on the 5th CHECK edge
    do_reset();
    add(1,0,0,0, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,0,0, 1,0,0);
    add(1,0,1,0, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,1,0, 1,0,0);
    add(1,0,1,1, 1,1,1);
    run_tab(3, "d4a");
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    check("d4a.first_err_vld", 16'(fv_a[3]), 16'd1);
    check("d4a.first_err_cyc", fc_a[3], 16'd4);
`endif
    // en dropped one cycle: refill ignores injected faults, no stale-history error
    add(0,0,1,0, 0,1,1);
    add(1,0,0,1, 0,1,1); add(1,0,1,1, 0,1,1); add(1,0,0,1, 0,1,1); add(1,0,0,1, 1,1,1);
    add(1,0,1,0, 1,1,1); add(1,0,0,0, 1,1,1);
    run_tab(3, "d4b");
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    check("d4b.first_err_vld", 16'(fv_a[3]), 16'd1);
    check("d4b.first_err_cyc", fc_a[3], 16'd4);
`endif

    // Asynchronous reset mid-CHECK with err set
    en = 1'b1;
    @(posedge clk); #1;
    check("pre_arst.checking", 16'(chk_a[3]), 16'd1);
    check("pre_arst.err", 16'(err_a[3]), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.checking", 16'(chk_a[3]), 16'd0);
    check("arst.err",      16'(err_a[3]), 16'd0);
    check("arst.err_cnt",  16'(cnt_a[3]), 16'd0);
`ifdef COMPOSE_CHK_FIRST_ERR_EN
    check("arst.first_err_vld", 16'(fv_a[3]), 16'd0);
    check("arst.first_err_cyc", fc_a[3], 16'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b0;

    // DEPTH=1: IDLE goes straight to CHECK
    do_reset();
    add(1,0,1,0, 1,0,0); add(1,0,0,0, 1,0,0); add(1,0,1,1, 1,1,1); add(1,0,0,0, 1,1,1);
    run_tab(4, "d1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
